mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL take parameter INSTRET_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 opcode  in  7  instruction-register bits [6:0], stable from DECODE until FETCH.
REQ-006 funct3  in  3  instruction-register bits [14:12].
REQ-007 funct7_5  in  1  instruction-register bit 30.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory access complete this cycle.
REQ-010 pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_out_we, reg_write, mem_to_reg, alu_src  out  1 each  datapath strobes/selects.
REQ-011 ALUCtl  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-012 state  out  3  current state encoding; illegal  out  1  trap flag; instret  out  INSTRET_W  retired count.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; outputs decode combinationally from state, opcode, funct fields, zero, mem_ready; unlisted outputs 0; ALUCtl 0000 outside EXEC.
REQ-014 FETCH: mem_read=1, i_or_d=0; hold while mem_ready=0; when mem_ready=1, ir_write=1, pc_write=1, pc_src=0, next DECODE.
REQ-015 DECODE: one cycle; legal opcode -> EXEC, else -> TRAP.
REQ-016 Legal: R 0110011 (f3 000 f7_5 0 ADD, f3 000 f7_5 1 SUB, f3 111 AND, f3 110 OR); I-ALU 0010011 (f3 000 ADD, 111 AND, 110 OR); LW 0000011 f3 010; SW 0100011 f3 010; BEQ 1100011 f3 000; anything else illegal.
REQ-017 EXEC R/I-ALU: alu_out_we=1, alu_src=0 (R) or 1 (I), ALUCtl per REQ-016, next WB.
REQ-018 EXEC LW/SW: alu_src=1, ALUCtl=0010, alu_out_we=1, next MEM.
REQ-019 EXEC BEQ: alu_src=0, ALUCtl=0110; if zero=1 then pc_write=1, pc_src=1; next FETCH; instruction retires.
REQ-020 MEM: i_or_d=1; mem_read=1 (LW) or mem_write=1 (SW); hold while mem_ready=0; on mem_ready=1 LW -> WB, SW -> FETCH and retires.
REQ-021 WB: reg_write=1, mem_to_reg=1 for LW else 0; next FETCH; retires.
REQ-022 TRAP: illegal=1, all strobes 0, ALUCtl 0000; remains until rst.
REQ-023 mem_ready ignored in DECODE, EXEC, WB, TRAP.
REQ-024 Latency with mem_ready tied 1: R/I 4 cycles, LW 5, SW 4, BEQ 3; each mem_ready=0 cycle adds one.

Reset
REQ-025 rst=1 SHALL force state=FETCH immediately, independent of clk, at any point including mid-MEM wait.
REQ-026 While rst=1 all strobes, ALUCtl, illegal SHALL be 0; instret SHALL be 0.
REQ-027 First FETCH access begins on first rising clk edge after rst falls.

Configuration
REQ-028 Macro MC_CTRL_INSTRET_EN defined: instret increments by 1 on each retire edge (REQ-019/020/021), wraps from all-ones to 0.
REQ-029 MC_CTRL_INSTRET_EN undefined: instret port present, tied to 0, no counter logic.

Verification
REQ-030 rst pulse, ADD (0110011/000/0), mem_ready=1 -> state 0,1,2,4,0; ALUCtl=0010 in EXEC; reg_write=1 in WB; instret=1.
REQ-031 SUB, AND, OR, ORI (0010011/110) -> EXEC ALUCtl 0110, 0000, 0001, 0001; alu_src 0,0,0,1.
REQ-032 LW, mem_ready low 3 cycles in MEM -> state held 3, mem_read=1, i_or_d=1; WB mem_to_reg=1; 8 cycles total.
REQ-033 BEQ zero=1 -> EXEC pc_write=1, pc_src=1; BEQ zero=0 -> pc_write=0; both return to FETCH, instret +1 each.
REQ-034 opcode 1111111 -> DECODE to TRAP, illegal=1, strobes 0 for 20 cycles; rst -> FETCH, illegal=0.
REQ-035 rst asserted during SW MEM wait -> state=0, mem_write=0 same cycle; instret=0; SW not retired.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// master: the controller (reads instruction fields and status, drives strobes).
// slave: the datapath side (drives instruction fields and status, reads strobes).
interface mc_ctrl_if #(
    parameter int unsigned INSTRET_W = 32
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 pc_src;
    logic                 ir_write;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 alu_out_we;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic [3:0]           ALUCtl;
    logic [2:0]           state;
    logic                 illegal;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_out_we,
        output reg_write, mem_to_reg, alu_src, ALUCtl, state, illegal, instret
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_out_we,
        input  reg_write, mem_to_reg, alu_src, ALUCtl, state, illegal, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle RV32-subset controller: FETCH/DECODE/EXEC/MEM/WB plus a sticky TRAP.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTRET_EN;
// otherwise instret reads as zero and no counter is built.
module mc_ctrl #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StTrap   = 3'd5;

    localparam logic [2:0] KindIll = 3'd0;
    localparam logic [2:0] KindR   = 3'd1;
    localparam logic [2:0] KindI   = 3'd2;
    localparam logic [2:0] KindLw  = 3'd3;
    localparam logic [2:0] KindSw  = 3'd4;
    localparam logic [2:0] KindBeq = 3'd5;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;

    logic [2:0] state_q, state_d;
    logic [2:0] kind;
    logic [3:0] alu_op;
    logic       retire;

    // Classify the instruction held in the IR and pick its ALU operation.
    always_comb begin
        kind   = KindIll;
        alu_op = AluAdd;
        case (bus.opcode)
            7'b0110011: begin
                case (bus.funct3)
                    3'b000:  begin kind = KindR; alu_op = bus.funct7_5 ? AluSub : AluAdd; end
                    3'b111:  begin kind = KindR; alu_op = AluAnd; end
                    3'b110:  begin kind = KindR; alu_op = AluOr;  end
                    default: ;
                endcase
            end
            7'b0010011: begin
                case (bus.funct3)
                    3'b000:  begin kind = KindI; alu_op = AluAdd; end
                    3'b111:  begin kind = KindI; alu_op = AluAnd; end
                    3'b110:  begin kind = KindI; alu_op = AluOr;  end
                    default: ;
                endcase
            end
            7'b0000011: if (bus.funct3 == 3'b010) kind = KindLw;
            7'b0100011: if (bus.funct3 == 3'b010) kind = KindSw;
            7'b1100011: if (bus.funct3 == 3'b000) kind = KindBeq;
            default: ;
        endcase
    end

    // Next state and datapath strobes; everything held low while reset is asserted.
    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_out_we = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.ALUCtl     = AluAnd;
        bus.illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = StDecode;
                    end
                end
                StDecode: state_d = (kind == KindIll) ? StTrap : StExec;
                StExec: begin
                    bus.ALUCtl = alu_op;
                    case (kind)
                        KindR, KindI: begin
                            bus.alu_out_we = 1'b1;
                            bus.alu_src    = (kind == KindI);
                            state_d        = StWb;
                        end
                        KindLw, KindSw: begin
                            bus.alu_out_we = 1'b1;
                            bus.alu_src    = 1'b1;
                            bus.ALUCtl     = AluAdd;
                            state_d        = StMem;
                        end
                        KindBeq: begin
                            bus.ALUCtl   = AluSub;
                            bus.pc_write = bus.zero;
                            bus.pc_src   = bus.zero;
                            retire       = 1'b1;
                            state_d      = StFetch;
                        end
                        // IR is stable past DECODE, so this is only reachable on a glitch.
                        default: begin
                            bus.ALUCtl = AluAnd;
                            state_d    = StTrap;
                        end
                    endcase
                end
                StMem: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = (kind == KindLw);
                    bus.mem_write = (kind == KindSw);
                    if (bus.mem_ready) begin
                        if (kind == KindLw) begin
                            state_d = StWb;
                        end else begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
                StWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (kind == KindLw);
                    retire         = 1'b1;
                    state_d        = StFetch;
                end
                StTrap:  bus.illegal = 1'b1;
                default: state_d = StFetch;
            endcase
        end
    end

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFetch;
        else     state_q <= state_d;
    end

    assign bus.state = state_q;

`ifdef MC_CTRL_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret_q <= '0;
        else if (retire) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

    assign bus.instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign bus.instret   = {INSTRET_W{1'b0}};
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction cycle schedules built from the latency and
// strobe rules drive an expectation that is compared on every falling edge.
module tb_mc_ctrl;
    localparam int unsigned W = 8;
`ifdef MC_CTRL_INSTRET_EN
    localparam bit InstretEn = 1'b1;
`else
    localparam bit InstretEn = 1'b0;
`endif

    // Strobe bit positions in the packed expectation vector.
    localparam logic [9:0] PCW  = 10'b10_0000_0000;
    localparam logic [9:0] PCS  = 10'b01_0000_0000;
    localparam logic [9:0] IRW  = 10'b00_1000_0000;
    localparam logic [9:0] IOD  = 10'b00_0100_0000;
    localparam logic [9:0] MRD  = 10'b00_0010_0000;
    localparam logic [9:0] MWR  = 10'b00_0001_0000;
    localparam logic [9:0] AOW  = 10'b00_0000_1000;
    localparam logic [9:0] RGW  = 10'b00_0000_0100;
    localparam logic [9:0] MTR  = 10'b00_0000_0010;
    localparam logic [9:0] ASRC = 10'b00_0000_0001;

    localparam int KIll = 0, KR = 1, KI = 2, KLw = 3, KSw = 4, KBeq = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_if #(.INSTRET_W(W)) bus();
    mc_ctrl #(.INSTRET_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic         exp_valid = 1'b0;
    logic [2:0]   exp_st;
    logic [9:0]   exp_sb;
    logic [3:0]   exp_alu;
    logic         exp_ill;
    logic [W-1:0] exp_ir;
    string        exp_tag = "";
    logic [W-1:0] model_ir = '0;

    logic [9:0] act_sb;
    assign act_sb = {bus.pc_write, bus.pc_src, bus.ir_write, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.alu_out_we, bus.reg_write, bus.mem_to_reg, bus.alu_src};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare every DUT output against the current expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            check({exp_tag, " state"},   32'(bus.state),   32'(exp_st));
            check({exp_tag, " strobes"}, 32'(act_sb),      32'(exp_sb));
            check({exp_tag, " ALUCtl"},  32'(bus.ALUCtl),  32'(exp_alu));
            check({exp_tag, " illegal"}, 32'(bus.illegal), 32'(exp_ill));
            check({exp_tag, " instret"}, 32'(bus.instret), 32'(exp_ir));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input string tag, input logic [2:0] st, input logic [9:0] sb,
                           input logic [3:0] alu, input logic ill);
        exp_tag   = tag;
        exp_st    = st;
        exp_sb    = sb;
        exp_alu   = alu;
        exp_ill   = ill;
        exp_ir    = InstretEn ? model_ir : '0;
        exp_valid = 1'b1;
    endtask

    // Instruction class and ALU code straight from the legal-encoding list.
    function automatic void classify(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     output int kind, output logic [3:0] alu);
        kind = KIll;
        alu  = 4'b0000;
        if (op == 7'b0110011 && f3 == 3'b000) begin kind = KR; alu = f7 ? 4'b0110 : 4'b0010; end
        if (op == 7'b0110011 && f3 == 3'b111) begin kind = KR; alu = 4'b0000; end
        if (op == 7'b0110011 && f3 == 3'b110) begin kind = KR; alu = 4'b0001; end
        if (op == 7'b0010011 && f3 == 3'b000) begin kind = KI; alu = 4'b0010; end
        if (op == 7'b0010011 && f3 == 3'b111) begin kind = KI; alu = 4'b0000; end
        if (op == 7'b0010011 && f3 == 3'b110) begin kind = KI; alu = 4'b0001; end
        if (op == 7'b0000011 && f3 == 3'b010) begin kind = KLw; alu = 4'b0010; end
        if (op == 7'b0100011 && f3 == 3'b010) begin kind = KSw; alu = 4'b0010; end
        if (op == 7'b1100011 && f3 == 3'b000) begin kind = KBeq; alu = 4'b0110; end
    endfunction

    // Drive one instruction through its schedule; returns cycles from first FETCH to retire.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw,
                             input bit abort_in_mem, output int cycles);
        int         kind;
        logic [3:0] alu;
        logic [9:0] sb;
        classify(op, f3, f7, kind, alu);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        bus.zero     = z;
        cycles       = 0;
        for (int i = 0; i < fw; i++) begin
            bus.mem_ready = 1'b0;
            set_exp({tag, " fetch-wait"}, 3'd0, MRD, 4'b0000, 1'b0);
            tick(); cycles++;
        end
        bus.mem_ready = 1'b1;
        set_exp({tag, " fetch"}, 3'd0, MRD | IRW | PCW, 4'b0000, 1'b0);
        tick(); cycles++;
        bus.mem_ready = 1'b0;
        set_exp({tag, " decode"}, 3'd1, 10'd0, 4'b0000, 1'b0);
        tick(); cycles++;
        if (kind == KIll) begin
            for (int i = 0; i < 20; i++) begin
                bus.mem_ready = i[0];
                set_exp({tag, " trap"}, 3'd5, 10'd0, 4'b0000, 1'b1);
                tick();
            end
            return;
        end
        bus.mem_ready = 1'b1;
        case (kind)
            KR:      sb = AOW;
            KI:      sb = AOW | ASRC;
            KBeq:    sb = z ? (PCW | PCS) : 10'd0;
            default: sb = AOW | ASRC;
        endcase
        set_exp({tag, " exec"}, 3'd2, sb, alu, 1'b0);
        tick(); cycles++;
        if (kind == KBeq) begin
            model_ir++;
            return;
        end
        if (kind == KLw || kind == KSw) begin
            sb = IOD | ((kind == KLw) ? MRD : MWR);
            for (int i = 0; i < mw; i++) begin
                if (abort_in_mem && i == 1) begin
                    exp_valid = 1'b0;
                    return;
                end
                bus.mem_ready = 1'b0;
                set_exp({tag, " mem-wait"}, 3'd3, sb, 4'b0000, 1'b0);
                tick(); cycles++;
            end
            bus.mem_ready = 1'b1;
            set_exp({tag, " mem"}, 3'd3, sb, 4'b0000, 1'b0);
            tick(); cycles++;
            if (kind == KSw) begin
                model_ir++;
                return;
            end
        end
        bus.mem_ready = 1'b1;
        set_exp({tag, " wb"}, 3'd4, RGW | ((kind == KLw) ? MTR : 10'd0), 4'b0000, 1'b0);
        tick(); cycles++;
        model_ir++;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        rst       = 1'b1;
        model_ir  = '0;
        set_exp("reset", 3'd0, 10'd0, 4'b0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    int cyc;

    initial begin
        bus.opcode    = 7'd0;
        bus.funct3    = 3'd0;
        bus.funct7_5  = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        do_reset();

        run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        check("add latency", 32'(cyc), 32'd4);
        check("add instret", 32'(bus.instret), InstretEn ? 32'd1 : 32'd0);
        run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, cyc);
        run_instr("and",  7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        run_instr("or",   7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        run_instr("ori",  7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        run_instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 2, 0, 1'b0, cyc);
        check("addi fetch-wait latency", 32'(cyc), 32'd6);
        run_instr("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        run_instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0, cyc);
        check("lw latency", 32'(cyc), 32'd8);
        run_instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        check("sw latency", 32'(cyc), 32'd4);
        run_instr("beq-t", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0, cyc);
        check("beq taken latency", 32'(cyc), 32'd3);
        run_instr("beq-nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        check("beq not-taken latency", 32'(cyc), 32'd3);
        check("instret after 11", 32'(bus.instret), InstretEn ? 32'd11 : 32'd0);

        run_instr("ill-op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        do_reset();
        check("post-trap illegal", 32'(bus.illegal), 32'd0);
        run_instr("lw-f3", 7'b0000011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        do_reset();
        run_instr("add2", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, cyc);

        // Asynchronous reset in the middle of an SW memory wait.
        run_instr("sw-abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 5, 1'b1, cyc);
        check("abort pre mem_write", 32'(bus.mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort state", 32'(bus.state), 32'd0);
        check("abort mem_write", 32'(bus.mem_write), 32'd0);
        check("abort strobes", 32'(act_sb), 32'd0);
        check("abort instret", 32'(bus.instret), 32'd0);
        model_ir = '0;
        tick();
        rst = 1'b0;
        run_instr("add3", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
        check("instret after abort+add", 32'(bus.instret), InstretEn ? 32'd1 : 32'd0);
        exp_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
